yz_sequence_monitor: RTL and testbench

- Downstream consumer of the Y/Z outputs of the lab gate-level circuit.
- Registers Y and Z on the shared clock.
- Detects the serial pattern 1011 on Y with overlapping matches, and detects rising edges on Z.
- Keeps event counters for lab observation and board display.

---
 rtl/yz_sequence_monitor.sv | 170 +++++++++++++++++
 tb/tb_yz_sequence_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yz_sequence_monitor.sv
// yz_sequence_monitor
//   Consumer of the Y/Z outputs of the lab gate-level circuit. Y and Z are
//   registered on CLK. The sampled Y stream is searched for the serial
//   pattern 1011, with overlapping matches allowed. Rising edges on the
//   sampled Z line are detected. Both kinds of event are counted for
//   observation and for the board display.
//
//   Optional build macro: YZ_GLITCH_FILTER_EN
//     When defined, a raw sample stage is added in front of the Y/Z
//     sample registers. The sample registers only take a new value when
//     two consecutive raw samples agree, so single-cycle glitches are
//     rejected. This adds one edge of latency to MATCH and Z_RISE.
//
//   Parameters
//     CNT_W : width of MATCH_CNT and Z_CNT
//     WRAP  : 0 = counters saturate at all-ones, 1 = counters wrap to 0
//
//   Ports
//     CLK       in   system clock, rising edge
//     RST_N     in   asynchronous active-low reset
//     EN        in   monitor enable; low freezes sampling, FSM and counters
//     Y         in   serial data from the upstream circuit
//     Z         in   event line from the upstream circuit
//     CLR_CNT   in   synchronous clear of both counters (works with EN low)
//     MATCH     out  one-cycle pulse when 1011 completes on Y
//     Z_RISE    out  one-cycle pulse per Z rising edge
//     MATCH_CNT out  number of matches
//     Z_CNT     out  number of Z rising edges
//     STATE     out  current FSM state encoding (debug)
module yz_sequence_monitor #(
  parameter int CNT_W = 8,
  parameter int WRAP  = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             Y,
  input  logic             Z,
  input  logic             CLR_CNT,
  output logic             MATCH,
  output logic             Z_RISE,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic [CNT_W-1:0] Z_CNT,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t stateQ;
  state_t stateNext;

  logic ySmp_p1;
  logic zSmp_p1;
  logic zDly_p2;
  logic matchNext;
  logic zRiseNext;

  function automatic logic [CNT_W-1:0] bumpCount(input logic [CNT_W-1:0] cnt);
    if ((WRAP == 0) && (&cnt)) begin
      return cnt;
    end
    return cnt + CNT_W'(1);
  endfunction

`ifdef YZ_GLITCH_FILTER_EN
  logic yRaw_p0;
  logic zRaw_p0;

  // Stage p0 -> p1: raw capture, then accept only values seen on two
  // consecutive edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      yRaw_p0 <= 1'b0;
      zRaw_p0 <= 1'b0;
      ySmp_p1 <= 1'b0;
      zSmp_p1 <= 1'b0;
      zDly_p2 <= 1'b0;
    end else if (EN) begin
      yRaw_p0 <= Y;
      zRaw_p0 <= Z;
      if (Y == yRaw_p0) begin
        ySmp_p1 <= yRaw_p0;
      end
      if (Z == zRaw_p0) begin
        zSmp_p1 <= zRaw_p0;
      end
      zDly_p2 <= zSmp_p1;
    end
  end
`else
  // Stage p1: direct sample of the pins, p2: one-edge delay of Z for edge
  // detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ySmp_p1 <= 1'b0;
      zSmp_p1 <= 1'b0;
      zDly_p2 <= 1'b0;
    end else if (EN) begin
      ySmp_p1 <= Y;
      zSmp_p1 <= Z;
      zDly_p2 <= zSmp_p1;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ <= S0;
    end else begin
      stateQ <= stateNext;
    end
  end

  // FSM next state. The state tracks the longest suffix of the sampled Y
  // stream that is a prefix of 1011; S4 falls back to S1/S2 so that
  // overlapping matches are found.
  always_comb begin
    stateNext = stateQ;
    if (EN) begin
      case (stateQ)
        S0:      stateNext = ySmp_p1 ? S1 : S0;
        S1:      stateNext = ySmp_p1 ? S1 : S2;
        S2:      stateNext = ySmp_p1 ? S3 : S0;
        S3:      stateNext = ySmp_p1 ? S4 : S2;
        S4:      stateNext = ySmp_p1 ? S1 : S2;
        default: stateNext = S0;
      endcase
    end
  end

  // FSM / event outputs (pre-register).
  always_comb begin
    matchNext = EN && (stateNext == S4);
    zRiseNext = EN && zSmp_p1 && !zDly_p2;
    STATE     = stateQ;
  end

  // Stage p3: registered pulses and event counters. A clear wins over a
  // simultaneous increment but leaves the pulses untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MATCH     <= 1'b0;
      Z_RISE    <= 1'b0;
      MATCH_CNT <= '0;
      Z_CNT     <= '0;
    end else begin
      MATCH  <= matchNext;
      Z_RISE <= zRiseNext;
      if (CLR_CNT) begin
        MATCH_CNT <= '0;
        Z_CNT     <= '0;
      end else begin
        if (matchNext) begin
          MATCH_CNT <= bumpCount(MATCH_CNT);
        end
        if (zRiseNext) begin
          Z_CNT <= bumpCount(Z_CNT);
        end
      end
    end
  end

endmodule

// File: tb/tb_yz_sequence_monitor.sv
// Testbench for yz_sequence_monitor. Three instances share the stimulus:
// the default CNT_W=8 saturating build, and CNT_W=2 builds in saturate and
// wrap mode for the counter overflow cases.
module tb_yz_sequence_monitor;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       Y;
  logic       Z;
  logic       CLR_CNT;

  logic       match;
  logic       zRise;
  logic [7:0] matchCnt;
  logic [7:0] zCnt;
  logic [2:0] state;

  logic       matchSat;
  logic       zRiseSat;
  logic [1:0] matchCntSat;
  logic [1:0] zCntSat;
  logic [2:0] stateSat;

  logic       matchWrap;
  logic       zRiseWrap;
  logic [1:0] matchCntWrap;
  logic [1:0] zCntWrap;
  logic [2:0] stateWrap;

  yz_sequence_monitor #(.CNT_W(8), .WRAP(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .Y(Y), .Z(Z), .CLR_CNT(CLR_CNT),
    .MATCH(match), .Z_RISE(zRise), .MATCH_CNT(matchCnt), .Z_CNT(zCnt),
    .STATE(state)
  );

  yz_sequence_monitor #(.CNT_W(2), .WRAP(0)) dutSat (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .Y(Y), .Z(Z), .CLR_CNT(CLR_CNT),
    .MATCH(matchSat), .Z_RISE(zRiseSat), .MATCH_CNT(matchCntSat),
    .Z_CNT(zCntSat), .STATE(stateSat)
  );

  yz_sequence_monitor #(.CNT_W(2), .WRAP(1)) dutWrap (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .Y(Y), .Z(Z), .CLR_CNT(CLR_CNT),
    .MATCH(matchWrap), .Z_RISE(zRiseWrap), .MATCH_CNT(matchCntWrap),
    .Z_CNT(zCntWrap), .STATE(stateWrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       en;
    logic       y;
    logic       z;
    logic       clr;
    logic       match;
    logic       zRise;
    logic [2:0] state;
    logic [7:0] mCnt;
    logic [7:0] zCnt;
  } vec_t;

  vec_t expQ[$];
  int   nCmp  = 0;
  int   nFail = 0;

  function automatic vec_t mk(input int en, input int y, input int z,
                              input int clr, input int m, input int zr,
                              input int st, input int mc, input int zc);
    vec_t v;
    v.en    = en[0];
    v.y     = y[0];
    v.z     = z[0];
    v.clr   = clr[0];
    v.match = m[0];
    v.zRise = zr[0];
    v.state = st[2:0];
    v.mCnt  = mc[7:0];
    v.zCnt  = zc[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pops the expectation pushed for this vector and compares all instances.
  task automatic checkOut(input int idx);
    vec_t e;
    if (expQ.size() == 0) begin
      nCmp++;
      nFail++;
      $display("FAIL v%0d scoreboard: got empty queue, expected an entry", idx);
    end else begin
      e = expQ.pop_front();
      chk($sformatf("v%0d MATCH", idx), 32'(match), 32'(e.match));
      chk($sformatf("v%0d Z_RISE", idx), 32'(zRise), 32'(e.zRise));
      chk($sformatf("v%0d STATE", idx), 32'(state), 32'(e.state));
      chk($sformatf("v%0d MATCH_CNT", idx), 32'(matchCnt), 32'(e.mCnt));
      chk($sformatf("v%0d Z_CNT", idx), 32'(zCnt), 32'(e.zCnt));
      chk($sformatf("v%0d sat MATCH", idx), 32'(matchSat), 32'(e.match));
      chk($sformatf("v%0d sat Z_RISE", idx), 32'(zRiseSat), 32'(e.zRise));
      chk($sformatf("v%0d sat STATE", idx), 32'(stateSat), 32'(e.state));
      chk($sformatf("v%0d wrap MATCH", idx), 32'(matchWrap), 32'(e.match));
      chk($sformatf("v%0d wrap Z_RISE", idx), 32'(zRiseWrap), 32'(e.zRise));
      chk($sformatf("v%0d wrap STATE", idx), 32'(stateWrap), 32'(e.state));
    end
  endtask

  // Drives one vector, pushes its expectation, then compares 1 unit after
  // the next rising edge.
  task automatic applyVec(input vec_t v, input int idx);
    EN      = v.en;
    Y       = v.y;
    Z       = v.z;
    CLR_CNT = v.clr;
    expQ.push_back(v);
    @(posedge CLK);
    #1;
    checkOut(idx);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, " MATCH"}, 32'(match), 32'd0);
    chk({tag, " Z_RISE"}, 32'(zRise), 32'd0);
    chk({tag, " STATE"}, 32'(state), 32'd0);
    chk({tag, " MATCH_CNT"}, 32'(matchCnt), 32'd0);
    chk({tag, " Z_CNT"}, 32'(zCnt), 32'd0);
  endtask

`ifndef YZ_GLITCH_FILTER_EN
  vec_t vecs[62];
`else
  vec_t fvecs[8];
`endif

  initial begin
    RST_N   = 1'b0;
    EN      = 1'b1;
    Y       = 1'b1;
    Z       = 1'b1;
    CLR_CNT = 1'b0;

`ifndef YZ_GLITCH_FILTER_EN
    // Columns: en, y, z, clr | MATCH, Z_RISE, STATE, MATCH_CNT, Z_CNT
    // (outputs as seen just after the edge that consumes the vector).
    // Z high at reset release -> one rise.
    vecs[0]  = mk(1,0,1,0, 0,0,0, 0,0);
    vecs[1]  = mk(1,0,1,0, 0,1,0, 0,1);
    vecs[2]  = mk(1,0,1,0, 0,0,0, 0,1);
    vecs[3]  = mk(1,0,0,0, 0,0,0, 0,1);
    // Basic 1011.
    vecs[4]  = mk(1,1,0,0, 0,0,0, 0,1);
    vecs[5]  = mk(1,0,0,0, 0,0,1, 0,1);
    vecs[6]  = mk(1,1,0,0, 0,0,2, 0,1);
    vecs[7]  = mk(1,1,0,0, 0,0,3, 0,1);
    vecs[8]  = mk(1,0,0,0, 1,0,4, 1,1);
    vecs[9]  = mk(1,0,0,0, 0,0,2, 1,1);
    vecs[10] = mk(1,0,0,0, 0,0,0, 1,1);
    // Overlap 1,0,1,1,0,1,1.
    vecs[11] = mk(1,1,0,0, 0,0,0, 1,1);
    vecs[12] = mk(1,0,0,0, 0,0,1, 1,1);
    vecs[13] = mk(1,1,0,0, 0,0,2, 1,1);
    vecs[14] = mk(1,1,0,0, 0,0,3, 1,1);
    vecs[15] = mk(1,0,0,0, 1,0,4, 2,1);
    vecs[16] = mk(1,1,0,0, 0,0,2, 2,1);
    vecs[17] = mk(1,1,0,0, 0,0,3, 2,1);
    vecs[18] = mk(1,0,0,0, 1,0,4, 3,1);
    vecs[19] = mk(1,0,0,0, 0,0,2, 3,1);
    vecs[20] = mk(1,0,0,0, 0,0,0, 3,1);
    // 1,1,1,1 never matches.
    vecs[21] = mk(1,1,0,0, 0,0,0, 3,1);
    vecs[22] = mk(1,1,0,0, 0,0,1, 3,1);
    vecs[23] = mk(1,1,0,0, 0,0,1, 3,1);
    vecs[24] = mk(1,1,0,0, 0,0,1, 3,1);
    vecs[25] = mk(1,0,0,0, 0,0,1, 3,1);
    vecs[26] = mk(1,0,0,0, 0,0,2, 3,1);
    vecs[27] = mk(1,0,0,1, 0,0,0, 0,0);
    // Z toggles three times, then high for 10 cycles.
    vecs[28] = mk(1,0,1,0, 0,0,0, 0,0);
    vecs[29] = mk(1,0,0,0, 0,1,0, 0,1);
    vecs[30] = mk(1,0,1,0, 0,0,0, 0,1);
    vecs[31] = mk(1,0,0,0, 0,1,0, 0,2);
    vecs[32] = mk(1,0,1,0, 0,0,0, 0,2);
    vecs[33] = mk(1,0,1,0, 0,1,0, 0,3);
    for (int i = 34; i <= 41; i++) vecs[i] = mk(1,0,1,0, 0,0,0, 0,3);
    // Two more rises (5 since the clear), then clear coincident with a rise.
    vecs[42] = mk(1,0,0,0, 0,0,0, 0,3);
    vecs[43] = mk(1,0,1,0, 0,0,0, 0,3);
    vecs[44] = mk(1,0,0,0, 0,1,0, 0,4);
    vecs[45] = mk(1,0,1,0, 0,0,0, 0,4);
    vecs[46] = mk(1,0,0,0, 0,1,0, 0,5);
    vecs[47] = mk(1,0,1,0, 0,0,0, 0,5);
    vecs[48] = mk(1,0,0,1, 0,1,0, 0,0);
    // Enable: 1,0 then EN low with Y toggling, then 1,1.
    vecs[49] = mk(1,1,0,0, 0,0,0, 0,0);
    vecs[50] = mk(1,0,0,0, 0,0,1, 0,0);
    vecs[51] = mk(0,1,0,0, 0,0,1, 0,0);
    vecs[52] = mk(0,0,0,0, 0,0,1, 0,0);
    vecs[53] = mk(0,1,0,0, 0,0,1, 0,0);
    vecs[54] = mk(0,0,0,0, 0,0,1, 0,0);
    vecs[55] = mk(1,1,0,0, 0,0,2, 0,0);
    vecs[56] = mk(1,1,0,0, 0,0,3, 0,0);
    vecs[57] = mk(1,0,0,0, 1,0,4, 1,0);
    vecs[58] = mk(1,0,0,0, 0,0,2, 1,0);
    // Clear with EN low, then activity before the mid-cycle reset.
    vecs[59] = mk(0,0,0,1, 0,0,2, 0,0);
    vecs[60] = mk(1,1,1,0, 0,0,0, 0,0);
    vecs[61] = mk(1,0,1,0, 0,1,1, 0,1);
`else
    // Filtered build: one-cycle Y glitch is dropped; Z rise takes 3 edges.
    fvecs[0] = mk(1,1,0,0, 0,0,0, 0,0);
    fvecs[1] = mk(1,0,0,0, 0,0,0, 0,0);
    fvecs[2] = mk(1,0,0,0, 0,0,0, 0,0);
    fvecs[3] = mk(1,0,0,0, 0,0,0, 0,0);
    fvecs[4] = mk(1,0,1,0, 0,0,0, 0,0);
    fvecs[5] = mk(1,0,1,0, 0,0,0, 0,0);
    fvecs[6] = mk(1,0,1,0, 0,1,0, 0,1);
    fvecs[7] = mk(1,0,1,0, 0,0,0, 0,1);
`endif

    // Reset held for 3 cycles with Y=Z=1.
    repeat (3) @(posedge CLK);
    #1;
    checkAllZero("reset");
    #3;
    RST_N = 1'b1;

`ifndef YZ_GLITCH_FILTER_EN
    for (int i = 0; i < 62; i++) begin
      applyVec(vecs[i], i);
      if (i == 18) begin
        chk("sat MATCH_CNT after 3 matches", 32'(matchCntSat), 32'd3);
        chk("wrap MATCH_CNT after 3 matches", 32'(matchCntWrap), 32'd3);
      end
      if (i == 46) begin
        chk("sat Z_CNT after 5 rises", 32'(zCntSat), 32'd3);
        chk("wrap Z_CNT after 5 rises", 32'(zCntWrap), 32'd1);
      end
      if (i == 48) begin
        chk("sat Z_CNT clear on rise", 32'(zCntSat), 32'd0);
        chk("wrap Z_CNT clear on rise", 32'(zCntWrap), 32'd0);
      end
    end

    // Asynchronous reset asserted mid-cycle while outputs are active.
    #2;
    RST_N = 1'b0;
    #1;
    checkAllZero("async reset");
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    // Z still high at release: exactly one rise, Z_CNT=1.
    applyVec(mk(1,0,1,0, 0,0,0, 0,0), 100);
    applyVec(mk(1,0,1,0, 0,1,0, 0,1), 101);
    applyVec(mk(1,0,1,0, 0,0,0, 0,1), 102);
    applyVec(mk(1,0,1,0, 0,0,0, 0,1), 103);
`else
    // Release with Y=Z=0 so the glitch test starts from a quiet line.
    RST_N = 1'b0;
    Y = 1'b0;
    Z = 1'b0;
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) applyVec(fvecs[i], i);
    chk("sat Z_CNT filtered", 32'(zCntSat), 32'd1);
    chk("wrap Z_CNT filtered", 32'(zCntWrap), 32'd1);
    chk("sat MATCH_CNT filtered", 32'(matchCntSat), 32'd0);
    chk("wrap MATCH_CNT filtered", 32'(matchCntWrap), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
